// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, addressing modes, IR field positions,
// fetch-state encoding and datapath widths.
// No ports (package).
package cpu_pkg;

    // Datapath widths
    localparam int unsigned PC_W   = 16;
    localparam int unsigned IR_W   = 32;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned MM_W   = 4;
    localparam int unsigned STAT_W = 4;

    // IR field bit positions
    localparam int unsigned IR_OPC_MSB = 31;
    localparam int unsigned IR_OPC_LSB = 28;
    localparam int unsigned IR_MM_MSB  = 27;
    localparam int unsigned IR_MM_LSB  = 24;
    localparam int unsigned IR_IMM_MSB = 15;
    localparam int unsigned IR_IMM_LSB = 0;

    // Opcodes
    localparam logic [OPC_W-1:0] OP_NOOP   = 4'd0;
    localparam logic [OPC_W-1:0] OP_LOD    = 4'd1;
    localparam logic [OPC_W-1:0] OP_STR    = 4'd2;
    localparam logic [OPC_W-1:0] OP_BRA    = 4'd4;
    localparam logic [OPC_W-1:0] OP_BRR    = 4'd5;
    localparam logic [OPC_W-1:0] OP_BNE    = 4'd6;
    localparam logic [OPC_W-1:0] OP_ALU_OP = 4'd8;
    localparam logic [OPC_W-1:0] OP_HLT    = 4'd15;

    // Addressing mode: immediate
    localparam logic [MM_W-1:0] AM_IMM = 4'd8;

    // Fetch timeout: number of unacknowledged REQ cycles before ERR
    localparam int unsigned TMO_W      = 4;
    localparam int unsigned TMO_CYCLES = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: controller control/status, instruction memory handshake
// and decoded instruction fields.
// Modports: master = controller/memory side, slave = fetch_unit.
interface fetch_unit_if;
    import cpu_pkg::*;

    // Controller -> fetch unit
    logic              fetch_req;
    logic              pc_write;
    logic              pc_sel;
    logic              br_sel;
    logic              pc_rst;
    logic [STAT_W-1:0] stat;

    // Instruction memory handshake
    logic [PC_W-1:0]   imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [IR_W-1:0]   imem_rdata;

    // Fetch unit -> controller
    logic [OPC_W-1:0]  opcode;
    logic [MM_W-1:0]   mm;
    logic [PC_W-1:0]   imm;
    logic [PC_W-1:0]   pc;
    logic              ir_valid;
    logic              fetch_busy;
    logic              br_taken;
    logic              fetch_err;

    modport master (
        output fetch_req, pc_write, pc_sel, br_sel, pc_rst, stat,
        output imem_ack, imem_rdata,
        input  imem_addr, imem_req,
        input  opcode, mm, imm, pc, ir_valid, fetch_busy, br_taken, fetch_err
    );

    modport slave (
        input  fetch_req, pc_write, pc_sel, br_sel, pc_rst, stat,
        input  imem_ack, imem_rdata,
        output imem_addr, imem_req,
        output opcode, mm, imm, pc, ir_valid, fetch_busy, br_taken, fetch_err
    );

endinterface : fetch_unit_if

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential (PC+1), absolute (IMM) or relative (PC+IMM).
// All arithmetic is modulo 2^16; IMM is two's complement in the relative case.
// Ports:
//   i_pc        current program counter
//   i_imm       immediate field from IR
//   i_pc_sel    0 = sequential, 1 = branch target
//   i_br_sel    0 = absolute target, 1 = relative target
//   o_pc_next_c combinational next PC
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_imm,
    input  logic            i_pc_sel,
    input  logic            i_br_sel,
    output logic [PC_W-1:0] o_pc_next_c
);

    // Truncating 16-bit add gives the wrap and two's-complement behaviour for free
    always_comb begin
        o_pc_next_c = PC_W'(i_pc + PC_W'(1));
        if (i_pc_sel) begin
            o_pc_next_c = i_br_sel ? PC_W'(i_pc + i_imm) : i_imm;
        end
    end

endmodule : pc_next_calc

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds PC and IR, runs the IMEM request/ack
// handshake and decodes opcode/mode/immediate and the branch-taken condition.
// Optional macro FETCH_TIMEOUT_EN: when defined, a fetch left unacknowledged
// for 15 REQ cycles moves the FSM to a sticky ERR state (FETCH_ERR=1).
// Ports:
//   i_clk  system clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    fetch_unit_if.slave (controller controls, IMEM handshake,
//          decoded IR fields, PC, IR_VALID, FETCH_BUSY, BR_TAKEN, FETCH_ERR)
module fetch_unit
    import cpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    fetch_unit_if.slave bus
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            w_ir_load;

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_calc;
    logic            w_pc_upd_en;
    logic [IR_W-1:0] r_ir;

    logic            r_imem_req;
    logic            r_fetch_busy;
    logic            r_ir_valid;
    logic            r_fetch_err;

    logic [OPC_W-1:0] w_opcode;
    logic [MM_W-1:0]  w_mm;
    logic [PC_W-1:0]  w_imm;
    logic             w_br_taken;
    logic             w_unused_ir;

`ifdef FETCH_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_tmo_hit;

    // Current cycle is the last unacknowledged REQ cycle allowed
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TMO_CYCLES - 1));
`endif

    // IR field decode
    assign w_opcode    = r_ir[IR_OPC_MSB:IR_OPC_LSB];
    assign w_mm        = r_ir[IR_MM_MSB:IR_MM_LSB];
    assign w_imm       = r_ir[IR_IMM_MSB:IR_IMM_LSB];
    assign w_unused_ir = ^r_ir[IR_MM_LSB-1:IR_IMM_MSB+1];

    // Next-PC arithmetic
    pc_next_calc u_pc_next_calc (
        .i_pc        (r_pc),
        .i_imm       (w_imm),
        .i_pc_sel    (bus.pc_sel),
        .i_br_sel    (bus.br_sel),
        .o_pc_next_c (w_pc_calc)
    );

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_ir_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.fetch_req) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    w_state_nxt = ST_DONE;
                    w_ir_load   = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_nxt = ST_ERR;
                end
`endif
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered status outputs, decoded from the state being entered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_imem_req   <= 1'b0;
            r_fetch_busy <= 1'b0;
            r_ir_valid   <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_imem_req   <= (w_state_nxt == ST_REQ);
            r_fetch_busy <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_DONE);
            r_ir_valid   <= (w_state_nxt == ST_DONE);
`ifdef FETCH_TIMEOUT_EN
            r_fetch_err  <= (w_state_nxt == ST_ERR);
`else
            r_fetch_err  <= 1'b0;
`endif
        end
    end

    // Instruction register: loads only on an acknowledged REQ cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ir <= '0;
        end else if (w_ir_load) begin
            r_ir <= bus.imem_rdata;
        end
    end

    // PC frozen while a request is outstanding so IMEM_ADDR stays stable
    assign w_pc_upd_en = (r_state != ST_REQ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= '0;
        end else if (w_pc_upd_en && bus.pc_rst) begin
            r_pc <= '0;
        end else if (w_pc_upd_en && bus.pc_write) begin
            r_pc <= w_pc_calc;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Timeout counter: cleared on REQ entry, counts unacknowledged REQ cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state != ST_REQ) && (w_state_nxt == ST_REQ)) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_REQ) && !bus.imem_ack) begin
            r_tmo_cnt <= TMO_W'(r_tmo_cnt + TMO_W'(1));
        end
    end
`endif

    // Branch condition from current IR and ALU status
    always_comb begin
        w_br_taken = 1'b0;
        case (w_opcode)
            OP_BRA, OP_BRR: w_br_taken = 1'b1;
            OP_BNE:         w_br_taken = |(bus.stat & w_mm);
            default:        w_br_taken = 1'b0;
        endcase
    end

    assign bus.imem_addr  = r_pc;
    assign bus.pc         = r_pc;
    assign bus.imem_req   = r_imem_req;
    assign bus.fetch_busy = r_fetch_busy;
    assign bus.ir_valid   = r_ir_valid;
    assign bus.fetch_err  = r_fetch_err;
    assign bus.opcode     = w_opcode;
    assign bus.mm         = w_mm;
    assign bus.imm        = w_imm;
    assign bus.br_taken   = w_br_taken;

endmodule : fetch_unit
